hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter NUM_SRC, default 2, source operands per instruction (1..4).
REQ-003 Parameter LOAD_LAT, default 1, load-use stall cycles (1..7).
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port id_valid  input  1  instruction in ID is valid.
REQ-007 Port id_src  input  NUM_SRC*REG_AW  ID-stage source register addresses; operand k at [k*REG_AW +: REG_AW].
REQ-008 Port ex_src  input  NUM_SRC*REG_AW  ID/EX source register addresses, same packing.
REQ-009 Port id_ex_rd, id_ex_regwrite, id_ex_memread  input  REG_AW/1/1  EX-stage destination and controls.
REQ-010 Port ex_mem_rd, ex_mem_regwrite  input  REG_AW/1  EX/MEM destination and write enable.
REQ-011 Port mem_wb_rd, mem_wb_regwrite  input  REG_AW/1  MEM/WB destination and write enable.
REQ-012 Port fwd_sel  output  NUM_SRC*2  per-operand forward select, 2 bits per operand.
REQ-013 Port pc_write_en, if_id_write_en  output  1/1  pipeline-advance enables.
REQ-014 Port id_ex_flush  output  1  insert bubble into ID/EX.
REQ-015 Port stall_active  output  1  high in every stall cycle.

Function
REQ-016 fwd_sel is combinational from current inputs: 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b00 = register file.
REQ-017 Operand k selects 2'b10 when ex_mem_regwrite, ex_mem_rd != 0, and ex_mem_rd == ex_src[k].
REQ-018 Otherwise 2'b01 when mem_wb_regwrite, mem_wb_rd != 0, and mem_wb_rd == ex_src[k]; otherwise 2'b00. EX/MEM has priority.
REQ-019 Load-use hazard = id_valid & id_ex_memread & id_ex_regwrite & id_ex_rd != 0 & (id_ex_rd matches any id_src operand).
REQ-020 FSM states: RUN and STALL; a down-counter cnt is 3 bits wide.
REQ-021 In RUN with no hazard: pc_write_en=1, if_id_write_en=1, id_ex_flush=0, stall_active=0.
REQ-022 In RUN with a hazard, the same cycle drives pc_write_en=0, if_id_write_en=0, id_ex_flush=1, stall_active=1.
REQ-023 On that hazard edge, if LOAD_LAT==1, remain in RUN; else go to STALL and load cnt=LOAD_LAT-1.
REQ-024 STALL drives the same stall outputs as REQ-022 and decrements cnt each edge. It returns to RUN on the edge where cnt==1.
REQ-025 Total stall cycles per hazard is exactly LOAD_LAT; the hazard input is ignored while in STALL.
REQ-026 Duplicate matches across operands raise only one hazard; no extra cycles.
REQ-027 id_valid=0 never starts a stall; a stall already in STALL runs to completion.

Reset
REQ-028 rst_n low asynchronously forces RUN, cnt=0, and statistics counters to 0.
REQ-029 While rst_n is low, outputs are pc_write_en=1, if_id_write_en=1, id_ex_flush=0, stall_active=0, and fwd_sel=0.
REQ-030 A reset asserted mid-stall aborts the stall; the first cycle after release is RUN.

Configuration
REQ-031 With macro HAZARD_FWD_STATS_EN defined, add outputs stall_cnt and fwd_cnt (32 bits each).
REQ-032 stall_cnt increments once per stall cycle.
REQ-033 fwd_cnt increments once per cycle in which any fwd_sel is nonzero. Both counters saturate at all-ones.
REQ-034 Without the macro, these ports and counters do not exist and all other behaviour is identical.

Structure
REQ-035 Package hazard_pkg holds the forward-select encodings FWD_NONE/FWD_MEMWB/FWD_EXMEM, the state enum RUN/STALL, and the counter width.
REQ-036 Sub-module fwd_sel_unit computes one operand's 2-bit select; it is instantiated NUM_SRC times with a generate loop.

Verification
REQ-037 Writes to r3 in EX/MEM and MEM/WB, ex_src0=3 -> fwd_sel[1:0]=2'b10 (priority).
REQ-038 MEM/WB writes r5, ex_src1=5, EX/MEM writes r0 matching an operand -> fwd_sel[3:2]=2'b01 and the r0 operand gets 2'b00.
REQ-039 LOAD_LAT=3, load to r7 in EX, id_src1=7 -> exactly 3 cycles of pc_write_en=0 and id_ex_flush=1, then RUN.
REQ-040 LOAD_LAT=3, rst_n pulsed low in the 2nd stall cycle -> stall outputs clear immediately; RUN after release.
REQ-041 Load to r7 with id_valid=0, or id_ex_rd=0 -> no stall.
REQ-042 With HAZARD_FWD_STATS_EN and LOAD_LAT=2, two load-use hazards -> stall_cnt=4.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard detection / forwarding unit:
//   FWD_NONE / FWD_MEMWB / FWD_EXMEM : per-operand forward-select encodings
//   state_e                          : stall controller states (RUN, STALL)
//   CNT_W                            : width of the stall down-counter
//   STAT_W                           : width of the optional statistics counters
package hazard_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam int CNT_W  = 3;
  localparam int STAT_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit
// Forward-select decision for one source operand sitting in ID/EX.
// Ports:
//   ex_src_i          : source register address of this operand
//   ex_mem_rd_i       : EX/MEM destination register
//   ex_mem_regwrite_i : EX/MEM writes the register file
//   mem_wb_rd_i       : MEM/WB destination register
//   mem_wb_regwrite_i : MEM/WB writes the register file
//   sel_o             : FWD_EXMEM, FWD_MEMWB or FWD_NONE
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_src_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_regwrite_i,
  output logic [1:0]        sel_o
);

  logic exMemHit;
  logic memWbHit;

  // r0 is hard-wired to zero, so a write to it never produces a forward.
  assign exMemHit = ex_mem_regwrite_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == ex_src_i);
  assign memWbHit = mem_wb_regwrite_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == ex_src_i);

  // The younger result (EX/MEM) wins when both stages hold the register.
  always_comb begin
    sel_o = FWD_NONE;
    if (exMemHit) begin
      sel_o = FWD_EXMEM;
    end else if (memWbHit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Data-forwarding selects and load-use stall control for a classic pipeline.
// Optional feature: define HAZARD_FWD_STATS_EN to add the stall_cnt / fwd_cnt
// saturating statistics outputs.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_valid, id_src      : instruction in ID and its packed source registers
//   ex_src                : packed source registers of the instruction in ID/EX
//   id_ex_rd/_regwrite/_memread : EX-stage destination and controls
//   ex_mem_rd/_regwrite   : EX/MEM destination and write enable
//   mem_wb_rd/_regwrite   : MEM/WB destination and write enable
//   fwd_sel               : 2-bit forward select per operand
//   pc_write_en, if_id_write_en : pipeline-advance enables (low while stalling)
//   id_ex_flush           : bubble into ID/EX
//   stall_active          : high in every stall cycle
//   stall_cnt, fwd_cnt    : (HAZARD_FWD_STATS_EN only) statistics counters
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_regwrite,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      pc_write_en,
  output logic                      if_id_write_en,
  output logic                      id_ex_flush,
  output logic                      stall_active
`ifdef HAZARD_FWD_STATS_EN
  ,
  output logic [STAT_W-1:0]         stall_cnt,
  output logic [STAT_W-1:0]         fwd_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] rawSel;
  logic             srcMatch;
  logic             loadUse;
  logic             stallNow;

  for (genvar k = 0; k < NUM_SRC; k++) begin : gSrc
    fwd_sel_unit #(
      .REG_AW(REG_AW)
    ) uSel (
      .ex_src_i          (ex_src[k*REG_AW +: REG_AW]),
      .ex_mem_rd_i       (ex_mem_rd),
      .ex_mem_regwrite_i (ex_mem_regwrite),
      .mem_wb_rd_i       (mem_wb_rd),
      .mem_wb_regwrite_i (mem_wb_regwrite),
      .sel_o             (rawSel[2*k +: 2])
    );
  end

  // Any operand matching the load destination is one hazard; duplicates
  // collapse into the single OR below.
  always_comb begin
    srcMatch = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src[k*REG_AW +: REG_AW] == id_ex_rd) begin
        srcMatch = 1'b1;
      end
    end
  end

  assign loadUse = id_valid && id_ex_memread && id_ex_regwrite && (id_ex_rd != '0) && srcMatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The detecting RUN cycle is itself the first stall cycle, so STALL only
  // has to cover the remaining LOAD_LAT-1 cycles and leaves when cnt hits 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stallNow = 1'b0;
    unique case (state_q)
      RUN: begin
        if (loadUse) begin
          stallNow = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
          end
        end
      end
      STALL: begin
        stallNow = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are gated by rst_n so they read idle for the whole reset window,
  // not just after the next clock edge.
  assign stall_active   = rst_n && stallNow;
  assign pc_write_en    = !stall_active;
  assign if_id_write_en = !stall_active;
  assign id_ex_flush    = stall_active;
  assign fwd_sel        = rst_n ? rawSel : '0;

`ifdef HAZARD_FWD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] fwd_cnt_q;

  // Both counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_active && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
      if ((|fwd_sel) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + STAT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// Directed bench for hazard_fwd_unit (REG_AW=5, NUM_SRC=2, LOAD_LAT=3).
// Each stimulus cycle pushes its hand-computed expected outputs into a
// scoreboard queue; a monitor on the falling edge pops and compares.
// With HAZARD_FWD_STATS_EN defined the statistics outputs are checked too.
module tb_hazard_fwd_unit;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int LOAD_LAT = 3;

  logic                      clk;
  logic                      rst_n;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      id_ex_regwrite;
  logic                      id_ex_memread;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      ex_mem_regwrite;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic                      mem_wb_regwrite;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      pc_write_en;
  logic                      if_id_write_en;
  logic                      id_ex_flush;
  logic                      stall_active;
`ifdef HAZARD_FWD_STATS_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;
`endif

  typedef struct {
    string       name;
    logic [7:0]  vec;
    bit          chkStats;
    logic [31:0] expStallCnt;
    logic [31:0] expFwdCnt;
  } exp_t;

  exp_t sbQ[$];
  exp_t monItem;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_unit #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_src          (id_src),
    .ex_src          (ex_src),
    .id_ex_rd        (id_ex_rd),
    .id_ex_regwrite  (id_ex_regwrite),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .fwd_sel         (fwd_sel),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .id_ex_flush     (id_ex_flush),
    .stall_active    (stall_active)
`ifdef HAZARD_FWD_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .fwd_cnt         (fwd_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one scoreboard entry against the live outputs.
  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {fwd_sel, pc_write_en, if_id_write_en, id_ex_flush, stall_active};
    checks++;
    if (act !== e.vec) begin
      errors++;
      $display("[TB] FAIL %s: {fwd_sel,pc_we,ifid_we,flush,stall} got %b expected %b",
               e.name, act, e.vec);
    end
`ifdef HAZARD_FWD_STATS_EN
    if (e.chkStats) begin
      checks++;
      if (stall_cnt !== e.expStallCnt) begin
        errors++;
        $display("[TB] FAIL %s_stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.expStallCnt);
      end
      checks++;
      if (fwd_cnt !== e.expFwdCnt) begin
        errors++;
        $display("[TB] FAIL %s_fwd_cnt: got %0d expected %0d", e.name, fwd_cnt, e.expFwdCnt);
      end
    end
`endif
  endtask

  // Monitor: outputs are settled by the falling edge, so pop and compare there.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      monItem = sbQ.pop_front();
      checkOutput(monItem);
    end
  end

  task automatic clearInputs();
    id_valid        = 1'b0;
    id_src          = '0;
    ex_src          = '0;
    id_ex_rd        = '0;
    id_ex_regwrite  = 1'b0;
    id_ex_memread   = 1'b0;
    ex_mem_rd       = '0;
    ex_mem_regwrite = 1'b0;
    mem_wb_rd       = '0;
    mem_wb_regwrite = 1'b0;
  endtask

  task automatic setLoad(input logic [REG_AW-1:0] rd);
    id_ex_rd       = rd;
    id_ex_regwrite = 1'b1;
    id_ex_memread  = 1'b1;
  endtask

  // Inputs are already driven; record the expectation for this cycle and
  // advance to just after the next rising edge.
  task automatic applyStimulus(input string nm, input logic [3:0] expFwd, input logic expStall,
                               input bit chk = 1'b0, input logic [31:0] sc = 0,
                               input logic [31:0] fc = 0);
    exp_t e;
    e.name        = nm;
    e.vec         = {expFwd, ~expStall, ~expStall, expStall, expStall};
    e.chkStats    = chk;
    e.expStallCnt = sc;
    e.expFwdCnt   = fc;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk);
    #1;

    // Reset held with forwarding and hazard conditions present: outputs idle.
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; ex_src = {5'd0, 5'd3};
    setLoad(5'd7); id_valid = 1'b1; id_src = {5'd7, 5'd1};
    applyStimulus("reset_outputs", 4'b0000, 1'b0);

    rst_n = 1'b1;
    clearInputs();
    applyStimulus("run_after_reset", 4'b0000, 1'b0);

    // Forwarding patterns.
    clearInputs();
    ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1;
    ex_src = {5'd0, 5'd3};
    applyStimulus("fwd_exmem_priority", 4'b0010, 1'b0);

    clearInputs();
    mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1; ex_mem_rd = 5'd0; ex_mem_regwrite = 1'b1;
    ex_src = {5'd5, 5'd0};
    applyStimulus("fwd_memwb_r0_ignored", 4'b0100, 1'b0);

    clearInputs();
    ex_mem_rd = 5'd5; mem_wb_rd = 5'd5; ex_src = {5'd5, 5'd5};
    applyStimulus("fwd_no_regwrite", 4'b0000, 1'b0);

    clearInputs();
    ex_mem_rd = 5'd4; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd4; mem_wb_regwrite = 1'b1;
    ex_src = {5'd4, 5'd4};
    applyStimulus("fwd_both_exmem", 4'b1010, 1'b0);

    clearInputs();
    ex_mem_rd = 5'd2; ex_mem_regwrite = 1'b1; mem_wb_rd = 5'd9; mem_wb_regwrite = 1'b1;
    ex_src = {5'd2, 5'd9};
    applyStimulus("fwd_mixed", 4'b1001, 1'b0);

    // Load-use conditions that must not stall.
    clearInputs();
    setLoad(5'd7); id_src = {5'd7, 5'd0}; id_valid = 1'b0;
    applyStimulus("nostall_invalid", 4'b0000, 1'b0);

    clearInputs();
    setLoad(5'd0); id_src = {5'd0, 5'd0}; id_valid = 1'b1;
    applyStimulus("nostall_rd0", 4'b0000, 1'b0);

    clearInputs();
    id_ex_rd = 5'd7; id_ex_regwrite = 1'b1; id_valid = 1'b1; id_src = {5'd7, 5'd0};
    applyStimulus("nostall_not_load", 4'b0000, 1'b0);

    clearInputs();
    id_ex_rd = 5'd7; id_ex_memread = 1'b1; id_valid = 1'b1; id_src = {5'd7, 5'd0};
    applyStimulus("nostall_no_regwrite", 4'b0000, 1'b0);

    // Load to r7 used by operand 1: three stall cycles, hazard held into STALL.
    clearInputs();
    setLoad(5'd7); id_valid = 1'b1; id_src = {5'd7, 5'd2};
    applyStimulus("lu_cycle1", 4'b0000, 1'b1);
    applyStimulus("lu_cycle2", 4'b0000, 1'b1);
    id_valid = 1'b0;
    applyStimulus("lu_cycle3", 4'b0000, 1'b1);
    clearInputs();
    applyStimulus("lu_done", 4'b0000, 1'b0);

    // Both operands match the load: still exactly three cycles.
    clearInputs();
    setLoad(5'd6); id_valid = 1'b1; id_src = {5'd6, 5'd6};
    applyStimulus("dup_cycle1", 4'b0000, 1'b1);
    applyStimulus("dup_cycle2", 4'b0000, 1'b1);
    clearInputs();
    applyStimulus("dup_cycle3", 4'b0000, 1'b1);
    applyStimulus("dup_done", 4'b0000, 1'b0, 1'b1, 32'd6, 32'd4);
    applyStimulus("dup_idle", 4'b0000, 1'b0);

    // Reset pulsed in the second stall cycle aborts the stall.
    clearInputs();
    setLoad(5'd7); id_valid = 1'b1; id_src = {5'd0, 5'd7};
    applyStimulus("rst_stall_cycle1", 4'b0000, 1'b1);
    clearInputs();
    rst_n = 1'b0;
    applyStimulus("rst_during_stall", 4'b0000, 1'b0);
    rst_n = 1'b1;
    applyStimulus("rst_release_run", 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0);
    applyStimulus("rst_idle", 4'b0000, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && sbQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sbQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
